// File: rtl/register_dump_unit_pkg.sv
// Shared constants and types for the register dump path to the debug UART.
// Also used by the debug controller for the byte interface width.
package register_dump_unit_pkg;

  localparam int NB_BYTE         = 8;
  localparam int UART_DATA_W     = NB_BYTE;
  localparam int NB_DATA_DEFAULT = 32;
  localparam int BYTES_PER_WORD  = NB_DATA_DEFAULT / NB_BYTE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

  function automatic int bytes_per_word(input int nb_data);
    return nb_data / NB_BYTE;
  endfunction

  // A one-byte word still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/register_dump_unit_word_byte_serializer.sv
// Holds one captured word and presents it MSB-first, one byte per handshake.
// Handshake: a byte transfers on any cycle where valid && ready; data is stable while valid && !ready.
module word_byte_serializer
  import register_dump_unit_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NB_DATA-1:0]     word_in,
  input  logic                   active,
  input  logic                   ready,
  output logic [UART_DATA_W-1:0] byte_out,
  output logic                   valid,
  output logic                   last,
  output logic                   fire
);

  localparam int NBYTES = bytes_per_word(NB_DATA);
  localparam int IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [NB_DATA-1:0] word_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   sel_idx;

  assign valid   = active;
  assign fire    = active && ready;
  assign last    = (idx_q == LAST_IDX);
  assign sel_idx = LAST_IDX - idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      idx_q  <= '0;
    end else if (fire && !last) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Output is forced to zero whenever no byte is offered.
  always_comb begin
    byte_out = '0;
    if (active) begin
      byte_out = word_q[sel_idx*NB_BYTE +: NB_BYTE];
    end
  end

endmodule

// File: rtl/register_dump_unit.sv
// Walks every register address, reads each word through the registered bank
// port and streams it MSB-first to the UART transmitter.
module register_dump_unit
  import register_dump_unit_pkg::*;
#(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic [NB_REG-1:0]      o_addr_r,
  input  logic [NB_DATA-1:0]     i_data_r,
  output logic [UART_DATA_W-1:0] o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output dump_state_t            o_state
);

  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGISTER - 1);

  dump_state_t       state_q, state_d;
  logic [NB_REG-1:0] addr_q, addr_d;
  logic              load;
  logic              active;
  logic              last;
  logic              fire;

  assign active = (state_q == ST_SEND);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_REQ;
          addr_d  = '0;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      // Bank data for addr_q is valid here, one cycle after REQ presented it.
      ST_WAIT: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (fire && last) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  word_byte_serializer #(
    .NB_DATA(NB_DATA)
  ) u_serializer (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .load    (load),
    .word_in (i_data_r),
    .active  (active),
    .ready   (i_tx_ready),
    .byte_out(o_tx_data),
    .valid   (o_tx_valid),
    .last    (last),
    .fire    (fire)
  );

  assign o_addr_r = addr_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_state  = state_q;

endmodule

// File: doc/register_dump_unit.md
# register_dump_unit

Debug-side reader for the decode-stage register bank: on a start pulse it walks every register address, reads each 32-bit word through the bank's registered read port, and streams it MSB-first as bytes over a valid/ready interface to the UART transmitter. It sits between the debug controller and the register bank read port A. The pipeline is halted and bank writes are disabled for the whole dump.

## Interface
- NB_REG, 5, register address width
- NB_DATA, 32, register word width; multiple of 8
- N_REGISTER, 32, number of registers dumped (addresses 0..N_REGISTER-1)
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  request a dump; sampled only in IDLE
- o_addr_r  out  NB_REG  read address to the bank read port
- i_data_r  in  NB_DATA  bank read data, registered: valid one cycle after the address is sampled
- o_tx_data  out  8  byte to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte this cycle
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE: o_addr_r=0, o_tx_valid=0. i_start=1 -> REQ, address counter 0.
- REQ: o_addr_r holds the current address; the bank samples it at the end of this cycle -> WAIT.
- WAIT: i_data_r is valid for the current address; capture into the word register, byte index=0 -> SEND.
- SEND: o_tx_valid=1, o_tx_data = word byte (NB_DATA/8-1-index), i.e. bits [31:24] first. On a valid&&ready cycle:
  - index < NB_DATA/8-1: index+1, stay in SEND.
  - last byte, address < N_REGISTER-1: address+1 -> REQ.
  - last byte, address = N_REGISTER-1 -> DONE.
- DONE: o_done=1 for exactly one cycle -> IDLE.
- o_addr_r is held constant from REQ through the final handshake of that word.
- Address counter is NB_REG bits and never wraps. The end condition is a compare against N_REGISTER-1.
- Output stream: N_REGISTER*NB_DATA/8 bytes, 128 with defaults, in order reg0 MSB .. reg31 LSB.

## Timing
- Reset (i_reset=0 at a rising edge): state IDLE; o_addr_r=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0; word register, index and address counter cleared. Reset takes priority over i_start and aborts a dump in any state. No further bytes are emitted after the reset edge.
- i_start high at edge E0 -> REQ after E0, WAIT after E1, first byte valid after E2.
- With i_tx_ready held high: 6 cycles per register (REQ, WAIT, 4×SEND). o_done is high in the cycle after the final handshake, i.e. 6·N_REGISTER+1 cycles after E0.
- Handshake rules:
  - Once o_tx_valid rises it stays high, and o_tx_data stays stable, until the handshake cycle.
  - i_tx_ready is never required before o_tx_valid.
  - i_tx_ready low stalls indefinitely with no data loss.
- i_start while busy, or during DONE, is ignored; it does not queue.
- i_data_r is sampled only in WAIT, so bank output changes in other cycles are don't-care.

## Structure
- Shared package contents:
  - state encoding localparams.
  - NB_BYTE=8.
  - bytes-per-word constant NB_DATA/NB_BYTE.
  - debug UART byte interface widths, also used by the debug controller.
- One natural sub-module: word_byte_serializer, which loads a word, presents bytes MSB-first under valid/ready and flags the last byte. The FSM and address counter stay in register_dump_unit.

## Test plan
- Bank preloaded with reg[k]=32'hA0B0C000+k, ready always 1, one start pulse -> 128 bytes starting A0 B0 C0 00 A0 B0 C0 01, ending A0 B0 C0 1F; o_done at cycle 193 after start; o_busy low afterward.
- Random i_tx_ready back-pressure (≈50% duty) -> identical byte sequence; o_tx_data and o_addr_r never change while valid&&!ready.
- i_start pulsed again mid-dump and in the DONE cycle -> ignored; exactly 128 bytes and one o_done pulse.
- i_reset=0 asserted during SEND of reg 7 byte 2 -> next cycle all outputs 0 and IDLE; a new start then dumps from reg0 byte 0.
- i_start and i_reset=0 in the same cycle -> stays IDLE, o_busy=0.
- N_REGISTER=4, NB_DATA=16 build -> 8 bytes, 4 cycles per register, o_done after cycle 17.
